// File: rtl/memwrite_display.sv
// Snoops CPU data-memory writes into a 16-entry shadow file and shows the switch-selected
// entry on LEDs and a 4-digit hex display. MEMWRITE_DISPLAY_DEBOUNCE_EN enables the switch debouncer.
module memwrite_display #(
    parameter int unsigned SCAN_DIV  = 50000,
    parameter int unsigned DB_CYCLES = 1000000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        memwrite,
    input  logic [15:0] writeaddr,
    input  logic [15:0] writedata,
    input  logic [3:0]  sw,
    output logic [15:0] LED,
    output logic [6:0]  seg,
    output logic [3:0]  an
);

    localparam logic [15:0] DIV_MAX = 16'(SCAN_DIV - 1);

    if (SCAN_DIV < 2 || SCAN_DIV > 65535 || DB_CYCLES < 2 || DB_CYCLES > 1048575)
    begin : g_bad_param
        $error("memwrite_display: parameter out of range");
    end

    logic [15:0] shadow_q [16];
    logic [15:0] shadow_d [16];
    logic [3:0]  sync1_q, sync1_d;
    logic [3:0]  sw_s_q, sw_s_d;
    logic [3:0]  sel_q, sel_d;
    logic [15:0] led_q, led_d;
    logic [15:0] div_q, div_d;
    logic [1:0]  digit_q, digit_d;
    logic [6:0]  seg_q, seg_d;
    logic [3:0]  an_q, an_d;
    logic        wr_hit;
    logic [3:0]  nib;

`ifdef MEMWRITE_DISPLAY_DEBOUNCE_EN
    localparam logic [19:0] DB_MAX = 20'(DB_CYCLES - 1);
    logic [3:0]  cand_q, cand_d;
    logic [19:0] dbcnt_q, dbcnt_d;
`endif

    function automatic logic [6:0] hex7(input logic [3:0] v);
        logic [6:0] p;
        case (v)
            4'h0: p = 7'h40;
            4'h1: p = 7'h79;
            4'h2: p = 7'h24;
            4'h3: p = 7'h30;
            4'h4: p = 7'h19;
            4'h5: p = 7'h12;
            4'h6: p = 7'h02;
            4'h7: p = 7'h78;
            4'h8: p = 7'h00;
            4'h9: p = 7'h10;
            4'hA: p = 7'h08;
            4'hB: p = 7'h03;
            4'hC: p = 7'h46;
            4'hD: p = 7'h21;
            4'hE: p = 7'h06;
            default: p = 7'h0E;
        endcase
        return p;
    endfunction

    always_comb begin
        wr_hit   = memwrite && (writeaddr[15:4] == 12'h000);
        shadow_d = shadow_q;
        if (wr_hit) shadow_d[writeaddr[3:0]] = writedata;
        // Write-first bypass so a write to the shown entry lands on LED immediately
        led_d = (wr_hit && writeaddr[3:0] == sel_q) ? writedata : shadow_q[sel_q];

        sync1_d = sw;
        sw_s_d  = sync1_q;
        sel_d   = sel_q;
`ifdef MEMWRITE_DISPLAY_DEBOUNCE_EN
        cand_d  = cand_q;
        dbcnt_d = dbcnt_q;
        if (sw_s_q != cand_q) begin
            cand_d  = sw_s_q;
            dbcnt_d = '0;
        end else begin
            if (dbcnt_q != DB_MAX) dbcnt_d = dbcnt_q + 20'd1;
            if (dbcnt_d == DB_MAX) sel_d = cand_q;
        end
`else
        sel_d = sw_s_q;
`endif

        nib     = led_q[{digit_q, 2'b00} +: 4];
        div_d   = div_q + 16'd1;
        digit_d = digit_q;
        seg_d   = seg_q;
        an_d    = an_q;
        if (div_q == DIV_MAX) begin
            div_d   = '0;
            digit_d = digit_q + 2'd1;
            seg_d   = hex7(nib);
            an_d    = ~(4'b0001 << digit_q);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            shadow_q <= '{default: '0};
            sync1_q  <= '0;
            sw_s_q   <= '0;
            sel_q    <= '0;
            led_q    <= '0;
            div_q    <= '0;
            digit_q  <= '0;
            seg_q    <= 7'h7F;
            an_q     <= 4'hF;
`ifdef MEMWRITE_DISPLAY_DEBOUNCE_EN
            cand_q   <= '0;
            dbcnt_q  <= '0;
`endif
        end else begin
            shadow_q <= shadow_d;
            sync1_q  <= sync1_d;
            sw_s_q   <= sw_s_d;
            sel_q    <= sel_d;
            led_q    <= led_d;
            div_q    <= div_d;
            digit_q  <= digit_d;
            seg_q    <= seg_d;
            an_q     <= an_d;
`ifdef MEMWRITE_DISPLAY_DEBOUNCE_EN
            cand_q   <= cand_d;
            dbcnt_q  <= dbcnt_d;
`endif
        end
    end

    assign LED = led_q;
    assign seg = seg_q;
    assign an  = an_q;

endmodule

// File: tb/tb_memwrite_display.sv
// Self-checking bench for memwrite_display: directed scenarios followed by
// randomized traffic, compared every cycle against a behavioural reference.
module tb_memwrite_display;

    localparam int SD = 4;
    localparam int DB = 8;

    logic        clk = 1'b0;
    logic        rst;
    logic        memwrite;
    logic [15:0] writeaddr;
    logic [15:0] writedata;
    logic [3:0]  sw;
    logic [15:0] LED;
    logic [6:0]  seg;
    logic [3:0]  an;

    int checks = 0;
    int errors = 0;

    logic [15:0] m_sh [16];
    logic [15:0] m_led;
    logic [3:0]  m_sel;
    logic [6:0]  m_seg;
    logic [3:0]  m_an;
    int          n;
    int          hist [$];
    logic [6:0]  hex_tab [16];

    memwrite_display #(.SCAN_DIV(SD), .DB_CYCLES(DB)) dut (
        .clk(clk), .rst(rst), .memwrite(memwrite), .writeaddr(writeaddr),
        .writedata(writedata), .sw(sw), .LED(LED), .seg(seg), .an(an)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Reference: sel follows the switch sample from two edges back, or (debounced)
    // only once the last DB samples ending two edges back all agree.
    task automatic model_edge();
        logic        wr;
        logic [15:0] nl;
        int          d;
        int          last;
        bit          same;
        if (rst) begin
            for (int i = 0; i < 16; i++) m_sh[i] = '0;
            m_led = '0;
            m_sel = '0;
            m_seg = 7'h7F;
            m_an  = 4'hF;
            n     = 0;
            hist  = {0, 0};
        end else begin
            wr = memwrite && (writeaddr[15:4] == 12'h000);
            nl = (wr && writeaddr[3:0] == m_sel) ? writedata : m_sh[m_sel];
            n++;
            if (n % SD == 0) begin
                d     = (n / SD - 1) % 4;
                m_seg = hex_tab[4'(m_led >> (4 * d))];
                m_an  = ~(4'b0001 << d);
            end
            m_led = nl;
            if (wr) m_sh[writeaddr[3:0]] = writedata;
            hist.push_back(int'(sw));
            last = hist.size() - 3;
`ifdef MEMWRITE_DISPLAY_DEBOUNCE_EN
            if (hist.size() >= DB + 2) begin
                same = 1'b1;
                for (int k = last - DB + 1; k <= last; k++)
                    if (hist[k] != hist[last]) same = 1'b0;
                if (same) m_sel = 4'(hist[last]);
            end
`else
            m_sel = 4'(hist[last]);
`endif
            while (hist.size() > 16) void'(hist.pop_front());
        end
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        chk("led_cycle", LED, m_led);
        chk("seg_cycle", {9'b0, seg}, {9'b0, m_seg});
        chk("an_cycle", {12'b0, an}, {12'b0, m_an});
    endtask

    task automatic steps(input int k);
        for (int i = 0; i < k; i++) step();
    endtask

    initial begin
        logic [3:0]  exp_an [4];
        logic [6:0]  exp_seg [4];
        logic [15:0] old_v;
        int          guard;
        int          hold;
        int          lat;

        hex_tab = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                    7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
        exp_an  = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};
        exp_seg = '{7'h0E, 7'h08, 7'h24, 7'h79};

        // Reset with a colliding write
        rst = 1'b1; memwrite = 1'b1; writeaddr = 16'h0003; writedata = 16'hBEEF; sw = 4'd3;
        steps(3);
        chk("rst_led", LED, 16'h0000);
        chk("rst_seg", {9'b0, seg}, 16'h007F);
        chk("rst_an", {12'b0, an}, 16'h000F);

        rst = 1'b0; memwrite = 1'b0;
        steps(3);
        chk("an_before_scan", {12'b0, an}, 16'h000F);
        steps(9);
        chk("rst_write_dropped", LED, 16'h0000);

        // Write and scan
        sw = 4'd4;
        steps(12);
        memwrite = 1'b1; writeaddr = 16'h0004; writedata = 16'h12AF;
        step();
        memwrite = 1'b0;
        chk("write_led", LED, 16'h12AF);
        guard = 0;
        while (an === 4'b1110 && guard < 20) begin step(); guard++; end
        while (an !== 4'b1110 && guard < 20) begin step(); guard++; end
        chk("scan_sync", {12'b0, an}, 16'h000E);
        for (int k = 0; k < 4; k++)
            for (int c = 0; c < 4; c++) begin
                chk("scan_an", {12'b0, an}, {12'b0, exp_an[k]});
                chk("scan_seg", {9'b0, seg}, {9'b0, exp_seg[k]});
                step();
            end

        // Ignored address
        memwrite = 1'b1; writeaddr = 16'h0014; writedata = 16'h5555;
        step();
        memwrite = 1'b0;
        steps(2);
        chk("ignored_addr", LED, 16'h12AF);

`ifdef MEMWRITE_DISPLAY_DEBOUNCE_EN
        memwrite = 1'b1; writeaddr = 16'h0007; writedata = 16'h7777;
        step();
        memwrite = 1'b0;
        sw = 4'd0;
        steps(12);
        chk("db_sel0", LED, 16'h0000);
        for (int t = 0; t < 10; t++) begin
            sw = (t % 2 == 0) ? 4'd7 : 4'd0;
            for (int c = 0; c < 3; c++) begin
                step();
                chk("db_bounce", LED, 16'h0000);
            end
        end
        sw = 4'd7;
        steps(10);
        chk("db_before", LED, 16'h0000);
        step();
        chk("db_after", LED, 16'h7777);
        old_v = 16'h7777;
        lat = DB + 2;
`else
        memwrite = 1'b1; writeaddr = 16'h0009; writedata = 16'h9999;
        step();
        memwrite = 1'b0;
        sw = 4'd0;
        steps(6);
        chk("nodb_sel0", LED, 16'h0000);
        sw = 4'd9;
        steps(3);
        chk("nodb_before", LED, 16'h0000);
        step();
        chk("nodb_after", LED, 16'h9999);
        old_v = 16'h9999;
        lat = 3;
`endif

        // Same-edge sel change and write to the new entry
        sw = 4'd2;
        steps(lat - 1);
        memwrite = 1'b1; writeaddr = 16'h0002; writedata = 16'hABCD;
        step();
        memwrite = 1'b0;
        chk("simul_old", LED, old_v);
        step();
        chk("simul_new", LED, 16'hABCD);

        // Randomized traffic with occasional reset
        hold = 0;
        for (int i = 0; i < 500; i++) begin
            if (hold == 0) begin
                sw   = 4'($urandom_range(0, 15));
                hold = $urandom_range(1, 14);
            end
            hold--;
            rst       = ($urandom_range(0, 149) == 0);
            memwrite  = 1'($urandom_range(0, 1));
            writeaddr = ($urandom_range(0, 3) == 0) ? 16'($urandom)
                                                    : {12'h000, 4'($urandom_range(0, 15))};
            writedata = 16'($urandom);
            step();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/memwrite_display.md
# memwrite_display

Board-side display stage downstream of the T16 CPU core. It snoops the CPU's data-memory write stream (`memwrite`/`writeaddr`/`writedata`) into a 16-entry shadow register file. It selects one entry with the board switches and drives both the 16 LEDs and a multiplexed 4-digit hex 7-segment display. It replaces the bare combinational LED lookup with a registered, reset-clean, debounced output stage.

## Interface
Parameters:
- `SCAN_DIV`, default 50000: clk cycles each digit stays lit; legal range 2..65535.
- `DB_CYCLES`, default 1000000: cycles the synchronized switch value must stay stable before it is accepted; legal range 2..2^20-1.

Ports:
- `clk`  in  1  system clock; one clock domain.
- `rst`  in  1  synchronous, active-high reset.
- `memwrite`  in  1  CPU data-memory write strobe.
- `writeaddr`  in  16  CPU write address.
- `writedata`  in  16  CPU write data.
- `sw`  in  4  raw board switches (asynchronous, bouncing); selects the shadow entry.
- `LED`  out  16  registered copy of the selected shadow entry.
- `seg`  out  7  segment drive, active-low, bit order {g,f,e,d,c,b,a}.
- `an`  out  4  digit enables, active-low; `an[0]` is the rightmost digit.

## Operation
- **Shadow file**: 16 x 16-bit storage. When `memwrite`=1 and `writeaddr[15:4]`=0, `shadow[writeaddr[3:0]] <= writedata`. Writes with any upper address bit set are ignored. There is one write per cycle.
- **Switch path**: `sw` passes through a 2-flop synchronizer (`sw_s`), then a debouncer.
  - The debouncer holds `cand` and a 20-bit counter.
  - If `sw_s != cand`: `cand <= sw_s` and the counter clears.
  - Else, if the counter reaches `DB_CYCLES-1`: `sel <= cand`, and the counter holds.
  - Else the counter increments.
- **LED**: each cycle, `LED <= (memwrite && writeaddr[15:4]==0 && writeaddr[3:0]==sel) ? writedata : shadow[sel]`. This write-first bypass means a write to the selected entry is never missed.
- **Display value**: `disp` is the same value as `LED`, taken from the same register.
- **Scan**:
  - A 16-bit `div` counts 0..`SCAN_DIV`-1 and wraps.
  - On wrap, a 2-bit `digit` increments 0→1→2→3→0.
  - Digit k shows `disp[4k+3:4k]` as hex 0-F in the standard 7-seg patterns. Example patterns: 0=7'h40, 8=7'h00, F=7'h0E (active-low).
  - `an` has only bit `digit` low.
  - `seg` and `an` are registered and update together.
- **Reset** (`rst`=1 at an edge):
  - The shadow file, `sel`, `cand`, the counters and `digit` clear to 0.
  - `LED`=16'h0000, `seg`=7'h7F (all segments off), `an`=4'hF.
  - Reset takes priority over a simultaneous `memwrite`: that write is dropped.
  - Reset mid-debounce discards the pending candidate.

## Timing
- **Write to LED**: a write sampled at edge N to the selected entry is visible on `LED` after edge N (one-edge latency, same edge as the shadow update).
- **Write to 7-seg**: the new value appears when the affected digit is next scanned, i.e. `seg` updates at the first scan edge after N.
- **First scan after reset**: after `rst` deasserts, the first `an`/`seg` drive is at the edge after `div` first reaches `SCAN_DIV`-1. Before then, `an` stays 4'hF.
- **Switch to `sel`**, with `DEBOUNCE_EN`: 2 synchronizer edges plus `DB_CYCLES` stable edges. `LED` follows one edge later.
- **Bouncing switch**: any toggle restarts the stability count. A switch that bounces continuously never changes `sel`.
- **Simultaneous `sel` change and write to the new `sel`**: `LED` uses the old `sel` that edge and shows the new entry, including that write, on the next edge.

## Configuration
- Macro: `MEMWRITE_DISPLAY_DEBOUNCE_EN`.
- **Defined**: the debouncer is as described above; `DB_CYCLES` is used.
- **Undefined**: the debouncer and its counter are not built. `sel <= sw_s` every cycle (latency 3 edges from `sw`), and `DB_CYCLES` is ignored.

## Test plan
Unless a scenario states otherwise, the bench uses `SCAN_DIV`=4, `DB_CYCLES`=8, and the macro defined.
- **Reset values**: hold `rst` for 3 cycles with `memwrite`=1, `writeaddr`=3, `writedata`=16'hBEEF → `LED`=0, `seg`=7'h7F, `an`=4'hF. After release, `sw`=3 settles and `LED` stays 0 (write dropped).
- **Write and scan**: `sw`=4 settled; write 16'h12AF to address 4 → `LED`=16'h12AF after that edge. The 7-seg cycles `an` 1110/1101/1011/0111 with `seg` F(7'h0E), A(7'h08), 2(7'h24), 1(7'h79), each held 4 cycles.
- **Ignored address**: write 16'h5555 to address 16'h0014 → no shadow entry changes; `LED` is unchanged.
- **Debounce**: toggle `sw` between 0 and 7 every 3 cycles for 30 cycles, then hold 7 → `sel` stays 0 throughout the toggling and becomes 7 exactly 2+8 edges after the final stable value. `LED` shows `shadow[7]` one edge later.
- **Simultaneous events**: same-edge write to the new `sel` plus `sel` change → old entry on `LED` that edge, new written value on the next edge.
- **Macro undefined**: `sw` 0→9 → `LED` shows `shadow[9]` 4 edges after `sw` changes.
